// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-control signals between the Datapath and the hazard controller.
// Optional macro HAZARD_PERF_EN adds the performance-counter outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic [REG_W-1:0] mem_rd;
    logic             mem_reg_write;
    logic             mem_access;
    logic [REG_W-1:0] wb_rd;
    logic             wb_reg_write;
    logic             dmem_ack;

    logic             dmem_req;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_events;
`endif

    // Datapath side: supplies pipeline state, consumes control.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect,
        output mem_rd, mem_reg_write, mem_access,
        output wb_rd, wb_reg_write, dmem_ack,
        input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, fwd_a, fwd_b, mem_err
`ifdef HAZARD_PERF_EN
        , input stall_cycles, flush_events
`endif
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect,
        input  mem_rd, mem_reg_write, mem_access,
        input  wb_rd, wb_reg_write, dmem_ack,
        output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, fwd_a, fwd_b, mem_err
`ifdef HAZARD_PERF_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, plus the
// MEM-stage req/ack sequencer with a wait-timeout watchdog.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int REG_W   = 5
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_ctrl_if.slave hif
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic req_w;
    logic mem_stall;
    logic load_use;
    logic pc_en_w, ifid_en_w, idex_en_w, exmem_en_w, memwb_en_w;
    logic ifid_flush_w, idex_flush_w;

    // wait_cnt holds the number of cycles the current access has already
    // stalled, so the first (RUN) request cycle is included in the budget.
    function automatic logic [1:0] fwdSel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] mrd,
        input logic             mwe,
        input logic [REG_W-1:0] wrd,
        input logic             wwe
    );
        if (mwe && mrd != X0 && mrd == rs)
            return 2'b10;
        else if (wwe && wrd != X0 && wrd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Memory sequencer state and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state, request and memory-stall decode; ack in the final allowed cycle still completes.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_w      = 1'b0;
        mem_stall  = 1'b0;
        case (state_q)
            RUN: begin
                req_w = hif.mem_access;
                if (hif.mem_access && !hif.dmem_ack) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                req_w = 1'b1;
                if (hif.dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                        state_d    = ERR;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Load-use detection; x0 is never a real producer.
    always_comb begin
        load_use = hif.ex_mem_read && (hif.ex_rd != X0) &&
                   ((hif.id_use_rs1 && hif.ex_rd == hif.id_rs1) ||
                    (hif.id_use_rs2 && hif.ex_rd == hif.id_rs2));
    end

    // Pipeline enable/flush priority: memory stall freezes everything (a held redirect waits), then redirect, then load-use.
    always_comb begin
        pc_en_w      = 1'b1;
        ifid_en_w    = 1'b1;
        idex_en_w    = 1'b1;
        exmem_en_w   = 1'b1;
        memwb_en_w   = 1'b1;
        ifid_flush_w = 1'b0;
        idex_flush_w = 1'b0;
        if (mem_stall) begin
            pc_en_w    = 1'b0;
            ifid_en_w  = 1'b0;
            idex_en_w  = 1'b0;
            exmem_en_w = 1'b0;
            memwb_en_w = 1'b0;
        end else if (hif.ex_redirect) begin
            ifid_flush_w = 1'b1;
            idex_flush_w = 1'b1;
        end else if (load_use) begin
            pc_en_w      = 1'b0;
            ifid_en_w    = 1'b0;
            idex_flush_w = 1'b1;
        end
    end

    // Outputs are gated by reset so they fall immediately when reset asserts.
    always_comb begin
        hif.dmem_req   = reset & req_w;
        hif.pc_en      = reset & pc_en_w;
        hif.ifid_en    = reset & ifid_en_w;
        hif.idex_en    = reset & idex_en_w;
        hif.exmem_en   = reset & exmem_en_w;
        hif.memwb_en   = reset & memwb_en_w;
        hif.ifid_flush = reset & ifid_flush_w;
        hif.idex_flush = reset & idex_flush_w;
        hif.mem_err    = reset & (state_q == ERR);
        hif.fwd_a      = reset ? fwdSel(hif.ex_rs1, hif.mem_rd, hif.mem_reg_write,
                                        hif.wb_rd, hif.wb_reg_write) : 2'b00;
        hif.fwd_b      = reset ? fwdSel(hif.ex_rs2, hif.mem_rd, hif.mem_reg_write,
                                        hif.wb_rd, hif.wb_reg_write) : 2'b00;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Saturating counters of stalled cycles and accepted redirects.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if ((mem_stall || load_use) && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (hif.ex_redirect && !mem_stall && flush_events_q != 32'hFFFF_FFFF)
            flush_events_d = flush_events_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign hif.stall_cycles = stall_cycles_q;
    assign hif.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4).
// Optional macro HAZARD_PERF_EN enables the counter checks.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if #(.REG_W(5)) hif ();

    pipeline_hazard_ctrl #(.TIMEOUT(4), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    localparam logic [6:0] ALLRUN = 7'b11111_00;
    localparam logic [6:0] STALL  = 7'b00000_00;
    localparam logic [6:0] REDIR  = 7'b11111_11;
    localparam logic [6:0] LDUSE  = 7'b00111_01;

    // Enables then flushes: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}.
    logic [6:0] ctrl;
    assign ctrl = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en,
                   hif.memwb_en, hif.ifid_flush, hif.idex_flush};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        hif.id_rs1 = '0;        hif.id_rs2 = '0;
        hif.id_use_rs1 = 1'b0;  hif.id_use_rs2 = 1'b0;
        hif.ex_rs1 = '0;        hif.ex_rs2 = '0;
        hif.ex_rd = '0;         hif.ex_mem_read = 1'b0;
        hif.ex_redirect = 1'b0;
        hif.mem_rd = '0;        hif.mem_reg_write = 1'b0;
        hif.mem_access = 1'b0;
        hif.wb_rd = '0;         hif.wb_reg_write = 1'b0;
        hif.dmem_ack = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clearInputs();

        // Reset held low: every output forced to 0 despite active inputs.
        reset = 1'b0;
        hif.mem_access = 1'b1;
        hif.ex_redirect = 1'b1;
        hif.mem_reg_write = 1'b1;
        hif.mem_rd = 5'd3;
        hif.ex_rs1 = 5'd3;
        #3;
        checkOutput("rst_ctrl", 32'(ctrl), 32'(STALL));
        checkOutput("rst_req", 32'(hif.dmem_req), 32'd0);
        checkOutput("rst_fwd_a", 32'(hif.fwd_a), 32'd0);
        checkOutput("rst_err", 32'(hif.mem_err), 32'd0);
        clearInputs();
        #4;
        reset = 1'b1;
        applyStimulus();
        checkOutput("idle_ctrl", 32'(ctrl), 32'(ALLRUN));
        checkOutput("idle_req", 32'(hif.dmem_req), 32'd0);

        // Forwarding.
        hif.mem_rd = 5'd3; hif.wb_rd = 5'd3;
        hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
        hif.ex_rs1 = 5'd3; hif.ex_rs2 = 5'd7;
        applyStimulus();
        checkOutput("fwd_a_mem", 32'(hif.fwd_a), 32'b10);
        checkOutput("fwd_b_none", 32'(hif.fwd_b), 32'b00);
        hif.mem_reg_write = 1'b0; hif.ex_rs2 = 5'd3;
        applyStimulus();
        checkOutput("fwd_a_wb", 32'(hif.fwd_a), 32'b01);
        checkOutput("fwd_b_wb", 32'(hif.fwd_b), 32'b01);
        hif.ex_rs1 = 5'd0;
        applyStimulus();
        checkOutput("fwd_a_rs0", 32'(hif.fwd_a), 32'b00);
        hif.mem_rd = 5'd0; hif.wb_rd = 5'd0;
        hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
        applyStimulus();
        checkOutput("fwd_a_x0", 32'(hif.fwd_a), 32'b00);
        hif.mem_rd = 5'd9; hif.wb_rd = 5'd4;
        hif.ex_rs1 = 5'd4; hif.ex_rs2 = 5'd9;
        applyStimulus();
        checkOutput("fwd_a_wb2", 32'(hif.fwd_a), 32'b01);
        checkOutput("fwd_b_mem2", 32'(hif.fwd_b), 32'b10);
        clearInputs();

        // Load-use on rs1, then the bubble cycle runs normally.
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5;
        hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
        applyStimulus();
        checkOutput("lu_rs1", 32'(ctrl), 32'(LDUSE));
        tick();
        hif.ex_mem_read = 1'b0;
        applyStimulus();
        checkOutput("lu_after", 32'(ctrl), 32'(ALLRUN));
        hif.ex_mem_read = 1'b1; hif.id_use_rs1 = 1'b0;
        applyStimulus();
        checkOutput("lu_unused", 32'(ctrl), 32'(ALLRUN));
        hif.id_use_rs2 = 1'b1; hif.id_rs2 = 5'd5;
        applyStimulus();
        checkOutput("lu_rs2", 32'(ctrl), 32'(LDUSE));
        hif.ex_redirect = 1'b1;
        applyStimulus();
        checkOutput("redir_over_lu", 32'(ctrl), 32'(REDIR));
        hif.ex_redirect = 1'b0; hif.ex_rd = 5'd0; hif.id_rs2 = 5'd0;
        applyStimulus();
        checkOutput("lu_x0", 32'(ctrl), 32'(ALLRUN));
        clearInputs();

        // Memory wait: ack in the 4th request cycle (exactly at the timeout limit).
        tick();
        hif.mem_access = 1'b1;
        applyStimulus();
        checkOutput("mw1_req", 32'(hif.dmem_req), 32'd1);
        checkOutput("mw1_ctrl", 32'(ctrl), 32'(STALL));
        tick();
        applyStimulus();
        checkOutput("mw2_req", 32'(hif.dmem_req), 32'd1);
        checkOutput("mw2_ctrl", 32'(ctrl), 32'(STALL));
        tick();
        applyStimulus();
        checkOutput("mw3_ctrl", 32'(ctrl), 32'(STALL));
        tick();
        hif.dmem_ack = 1'b1;
        applyStimulus();
        checkOutput("mw4_req", 32'(hif.dmem_req), 32'd1);
        checkOutput("mw4_ctrl", 32'(ctrl), 32'(ALLRUN));
        tick();
        hif.mem_access = 1'b0; hif.dmem_ack = 1'b0;
        applyStimulus();
        checkOutput("mw_done_req", 32'(hif.dmem_req), 32'd0);
        checkOutput("mw_done_err", 32'(hif.mem_err), 32'd0);

        // Zero-wait access.
        hif.mem_access = 1'b1; hif.dmem_ack = 1'b1;
        applyStimulus();
        checkOutput("zw_req", 32'(hif.dmem_req), 32'd1);
        checkOutput("zw_ctrl", 32'(ctrl), 32'(ALLRUN));
        tick();
        hif.mem_access = 1'b0; hif.dmem_ack = 1'b0;
        applyStimulus();
        checkOutput("zw_after_req", 32'(hif.dmem_req), 32'd0);

        // Redirect held during a memory wait, applied on the ack cycle.
        hif.mem_access = 1'b1; hif.ex_redirect = 1'b1;
        applyStimulus();
        checkOutput("rw1_ctrl", 32'(ctrl), 32'(STALL));
        tick();
        applyStimulus();
        checkOutput("rw2_ctrl", 32'(ctrl), 32'(STALL));
        tick();
        hif.dmem_ack = 1'b1;
        applyStimulus();
        checkOutput("rw_ack_ctrl", 32'(ctrl), 32'(REDIR));
        tick();
        clearInputs();
        applyStimulus();
        checkOutput("rw_after_ctrl", 32'(ctrl), 32'(ALLRUN));

        // Timeout: four request cycles without ack, then ERR.
        hif.mem_access = 1'b1;
        applyStimulus();
        checkOutput("to1_req", 32'(hif.dmem_req), 32'd1);
        tick();
        applyStimulus();
        checkOutput("to2_req", 32'(hif.dmem_req), 32'd1);
        tick();
        applyStimulus();
        checkOutput("to3_err", 32'(hif.mem_err), 32'd0);
        tick();
        applyStimulus();
        checkOutput("to4_req", 32'(hif.dmem_req), 32'd1);
        checkOutput("to4_err", 32'(hif.mem_err), 32'd0);
        tick();
        hif.ex_redirect = 1'b1;
        applyStimulus();
        checkOutput("err_flag", 32'(hif.mem_err), 32'd1);
        checkOutput("err_req", 32'(hif.dmem_req), 32'd0);
        checkOutput("err_ctrl", 32'(ctrl), 32'(STALL));
        tick();
        hif.dmem_ack = 1'b1;
        applyStimulus();
        checkOutput("err_sticky", 32'(hif.mem_err), 32'd1);
        checkOutput("err_sticky_ctrl", 32'(ctrl), 32'(STALL));

        // Asynchronous reset mid-cycle clears the error immediately.
        reset = 1'b0;
        applyStimulus();
        checkOutput("arst_err", 32'(hif.mem_err), 32'd0);
        checkOutput("arst_ctrl", 32'(ctrl), 32'(STALL));
        clearInputs();
        reset = 1'b1;
        applyStimulus();
        checkOutput("arst_rel_ctrl", 32'(ctrl), 32'(ALLRUN));
        checkOutput("arst_rel_err", 32'(hif.mem_err), 32'd0);

`ifdef HAZARD_PERF_EN
        // Counters: 2 load-use cycles + 3 memory-stall cycles, 1 redirect.
        checkOutput("perf_rst_stall", hif.stall_cycles, 32'd0);
        checkOutput("perf_rst_flush", hif.flush_events, 32'd0);
        hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5;
        hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
        tick();
        tick();
        clearInputs();
        hif.mem_access = 1'b1;
        tick();
        tick();
        tick();
        hif.dmem_ack = 1'b1;
        tick();
        clearInputs();
        hif.ex_redirect = 1'b1;
        tick();
        clearInputs();
        applyStimulus();
        checkOutput("perf_stall", hif.stall_cycles, 32'd5);
        checkOutput("perf_flush", hif.flush_events, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline Datapath.
- Detects load-use hazards, squashes wrong-path instructions on EX redirects, and generates EX-stage forwarding selects.
- Sequences MEM-stage data-memory accesses over a req/ack handshake, with a wait-timeout watchdog.
- Instantiated inside Datapath. Drives all pipeline-register enable/flush controls and the PC enable.

Parameters:
- TIMEOUT, 64, max cycles in MEM_WAIT before declaring a memory error; legal range >= 1.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  REG_W  source registers in EX.
- ex_rd  in  REG_W  destination register in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch/jal/jalr.
- mem_rd  in  REG_W  destination register in MEM.
- mem_reg_write  in  1  MEM instruction writes a register.
- mem_access  in  1  MEM holds a valid load/store.
- wb_rd  in  REG_W  destination register in WB.
- wb_reg_write  in  1  WB instruction writes a register.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  pipeline-register enables.
- ifid_flush, idex_flush  out  1  insert a NOP into IF/ID or ID/EX.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- mem_err  out  1  sticky memory-timeout error.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset (reset=0) forces RUN, wait_cnt=0, mem_err=0. All outputs are 0 while reset=0; dmem_req drops asynchronously.
- dmem_req = (RUN & mem_access) | MEM_WAIT.
- mem_stall = dmem_req & ~dmem_ack, or state==ERR.
- RUN → MEM_WAIT when mem_access & ~dmem_ack. Ack in the request cycle is a zero-wait access: no stall, stay in RUN.
- MEM_WAIT: wait_cnt increments each cycle. dmem_ack → RUN and clear wait_cnt. wait_cnt==TIMEOUT-1 without ack → ERR. Ack on that same cycle wins.
- ERR: dmem_req=0, mem_err=1, all enables 0. Exit only via reset.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- Control priority, highest first:
  - mem_stall: all five enables 0, no flushes. A pending redirect is held and applied on release.
  - ex_redirect: all enables 1, ifid_flush=idex_flush=1. load_use is ignored because the ID instruction is squashed.
  - load_use: pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
  - Otherwise: all enables 1, no flushes.
- Forwarding, per operand:
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rsX.
  - else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rsX.
  - else 00.
  - Combinational, 0-cycle latency, and independent of stall state.
- Register x0 never triggers a hazard or a forward.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments each cycle with mem_stall | load_use.
  - flush_events increments on each ex_redirect accepted while not mem_stall.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle with pc_en=ifid_en=0, idex_flush=1; next cycle all enables 1.
- Forwarding: mem_rd=wb_rd=3, both write, ex_rs1=3 → fwd_a=10. With mem_reg_write=0 → fwd_a=01. With ex_rs1=0 → 00.
- Memory wait: mem_access=1, ack after 3 cycles → dmem_req high 4 cycles, enables 0 for 3 cycles, state back to RUN. Ack in the request cycle → no stall.
- Redirect during wait: ex_redirect=1 while in MEM_WAIT → no flush until the ack cycle, then ifid_flush=idex_flush=1.
- Timeout: TIMEOUT=4, no ack → ERR after 4 request cycles, mem_err=1, dmem_req=0, enables 0. Asserting reset=0 asynchronously clears everything.
- With HAZARD_PERF_EN: 2 load-use stalls + 3-cycle memory wait → stall_cycles=5; 1 redirect → flush_events=1.
